// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and helpers for the register file with scoreboard.
// Holds the default geometry, the address-width function and the hardwired-zero address.
package reg_file_sb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int ZERO_ADDR = 0;

    // Smallest r with 2**r >= value; DEPTH is a power of two, so this is exact.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_sb_reg.sv
// Generic WIDTH-bit storage cell with load enable and asynchronous active-low clear.
// The top level instantiates one of these per architectural register.
module reg_param #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass and a per-register pending scoreboard.
// Decode reads operands and reserves destinations; writeback writes data and retires reservations.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = log2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 rsv,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ok,
    input  logic                 flush,
    output logic [AW:0]          pend_cnt
);

    logic [WIDTH-1:0] w_regQ [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [AW:0]      r_pendCnt;

    logic w_rsvZero;
    logic w_rsvPend;
    logic w_rsvWrHit;
    logic w_set;
    logic w_inc;
    logic w_clr;

    genvar g;

    for (g = 0; g < DEPTH; g++) begin : gen_regs
        logic w_en;
        assign w_en = wr && (waddr == AW'(g)) && !(ZERO_REG && (g == ZERO_ADDR));
        reg_param #(.WIDTH(WIDTH)) u_reg (
            .clk  (clk),
            .rstn (rstn),
            .i_en (w_en),
            .i_d  (wdata),
            .o_q  (w_regQ[g])
        );
    end

    // A same-cycle write to the read address forwards wdata and hides the pending bit.
    for (g = 0; g < NRD; g++) begin : gen_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;
        logic          w_zero;
        assign w_addr = raddr[g*AW +: AW];
        assign w_hit  = wr && (waddr == w_addr);
        assign w_zero = ZERO_REG && (w_addr == AW'(ZERO_ADDR));
        assign rdata[g*WIDTH +: WIDTH] = (!rstn || w_zero) ? '0 :
                                         w_hit             ? wdata : w_regQ[w_addr];
        assign rbusy[g] = rstn && r_pend[w_addr] && !w_hit;
    end

    assign w_rsvZero  = ZERO_REG && (rsv_addr == AW'(ZERO_ADDR));
    assign w_rsvPend  = r_pend[rsv_addr];
    assign w_rsvWrHit = wr && (waddr == rsv_addr);
    assign rsv_ok     = rstn && rsv && !flush && (w_rsvZero || !w_rsvPend || w_rsvWrHit);

    // Re-reserving an already pending register keeps both the bit and the count as they are.
    assign w_set = rsv_ok && !w_rsvZero;
    assign w_inc = w_set && !w_rsvPend;
    assign w_clr = wr && r_pend[waddr] && !(w_set && (rsv_addr == waddr));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend    <= '0;
            r_pendCnt <= '0;
        end else if (flush) begin
            r_pend    <= '0;
            r_pendCnt <= '0;
        end else begin
            if (w_clr) begin
                r_pend[waddr] <= 1'b0;
            end
            if (w_set) begin
                r_pend[rsv_addr] <= 1'b1;
            end
            if (w_inc && !w_clr) begin
                r_pendCnt <= r_pendCnt + (AW+1)'(1);
            end else if (!w_inc && w_clr) begin
                r_pendCnt <= r_pendCnt - (AW+1)'(1);
            end
        end
    end

    assign pend_cnt = r_pendCnt;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file with an integrated scoreboard for the processor datapath. It is the next generation of the 8x16 two-read-port file: width, depth and read-port count are parameters, and write-to-read bypass is qualified by the write strobe. Per-register pending bits let the decode stage reserve a destination at issue and detect RAW/WAW hazards before writeback. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 8, number of registers; power of two, ≥2. Derived AW = log2(DEPTH).
- NRD, 2, number of independent read ports (≥1).
- ZERO_REG, 0, when 1 register 0 is hardwired to zero and never pending.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- wr  in  1  write strobe.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- rdata  out  NRD*WIDTH  read data, port i at [i*WIDTH +: WIDTH].
- rbusy  out  NRD  port i's register is pending and not being written this cycle.
- rsv  in  1  reservation request (mark rsv_addr pending).
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle.
- flush  in  1  clear all pending bits.
- pend_cnt  out  AW+1  number of pending registers.

## Operation
- Storage: DEPTH registers of WIDTH bits, all 0 after reset. On edge with wr=1, reg[waddr] <= wdata; with ZERO_REG=1 writes to address 0 are dropped.
- Read (combinational, per port i): if wr and waddr==raddr_i (and not the zero register) then rdata_i = wdata (bypass), else reg[raddr_i]. Zero register always reads 0. While rstn=0, rdata = 0.
- Pending bits: pend[DEPTH], all 0 after reset.
- rbusy_i = pend[raddr_i] & ~(wr & waddr==raddr_i).
- rsv_ok = rsv & ~flush & (~pend[rsv_addr] | (wr & waddr==rsv_addr)); forced 1 for the zero register when rsv & ~flush. A refused reservation (rsv_ok=0) changes nothing; the requester holds rsv and retries.
- Pending update per edge, in priority order: flush -> all pend cleared (rsv ignored); else rsv_ok to non-zero register -> pend[rsv_addr] set; a write clears pend[waddr] unless that same address is being reserved this cycle (reservation wins: the new producer owns it, while the data write still occurs).
- pend_cnt is a registered population count of pend, maintained incrementally: +1 on a set, -1 on a clear, net 0 when both hit different registers in one cycle; reset and flush set it to 0. A write to a non-pending register does not decrement.

## Timing
- Read latency 0 (combinational); a write is visible the same cycle through the bypass and from storage on the following cycle.
- Reservation takes effect at the edge; rbusy on that register rises the next cycle.
- Write clears rbusy combinationally in the write cycle, and pend at the edge.
- Reset mid-operation: registers, pend and pend_cnt clear immediately, without waiting for a clock; rdata=0, rbusy=0, rsv_ok=0 and pend_cnt=0 while rstn is low.
- Outputs after reset release: rdata=0, rbusy=0, pend_cnt=0; rsv_ok follows rsv.

## Structure
- Shared package/header: DEPTH/WIDTH defaults, the log2 function, and the hardwired-zero address constant.
- One sub-module, reg_param: a WIDTH-bit register with enable and async active-low reset (the generalisation of the 16-bit register cell), instantiated DEPTH times.
- Read mux, bypass compare and scoreboard are in the top level, using a generate loop over NRD.

## Test plan
- Reset, then write 0xA5A5 to r3, then read r3 on both ports the next cycle -> 0xA5A5; in the write cycle itself, both ports also return 0xA5A5 via bypass.
- With wr=0 and waddr=r3, read r3 -> stored value, not wdata; with ZERO_REG=1, write 0xFFFF to r0 -> reads 0, rsv r0 -> rsv_ok=1, pend_cnt stays 0.
- Reserve r5 -> rsv_ok=1, next cycle rbusy=1 on r5 and pend_cnt=1; reserve r5 again -> rsv_ok=0; write r5 -> rbusy=0 that cycle, pend_cnt=0 next cycle.
- While r5 is pending, reserve r5 and write r5 in the same cycle -> rsv_ok=1, data written, pend[r5] stays 1, pend_cnt unchanged.
- Reserve r1, r2, r3 on successive cycles (pend_cnt=3), then assert flush together with rsv r4 -> rsv_ok=0, pend_cnt=0, all rbusy=0.
- With r2 pending and a register written, drop rstn between clock edges -> all outputs go to 0 immediately; after release, r2 is not busy and reads 0.
